// File: rtl/seq_detect_ctrl.sv
// Word-serial "1100" pattern counter: latches a word, streams it MSB first through
// an overlapping Moore detector and reports the saturated match count over a valid/ready handshake.
module seq_detect_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy,
    output logic              det_z
);

    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {StIdle, StShift, StReport} state_e;
    typedef enum logic [2:0] {DetD0, DetD1, DetD2, DetD3, DetD4} det_e;

    state_e            state_q, state_d;
    det_e              det_q, det_d, det_next;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cur_bit;

    assign cur_bit = shift_q[DATA_W-1];

    // Overlapping detector: after "1100" a following '1' restarts at D1.
    always_comb begin
        det_next = DetD0;
        unique case (det_q)
            DetD0:   det_next = cur_bit ? DetD1 : DetD0;
            DetD1:   det_next = cur_bit ? DetD2 : DetD0;
            DetD2:   det_next = cur_bit ? DetD2 : DetD3;
            DetD3:   det_next = cur_bit ? DetD1 : DetD4;
            DetD4:   det_next = cur_bit ? DetD1 : DetD0;
            default: det_next = DetD0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        det_d     = det_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d = in_data;
                    bit_d   = '0;
                    cnt_d   = '0;
                    det_d   = DetD0;
                    state_d = StShift;
                end
            end
            StShift: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    det_d   = det_next;
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    bit_d   = bit_q + BIT_W'(1);
                    if (det_next == DetD4 && cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (bit_q == LAST_BIT) begin
                        state_d = StReport;
                    end
                end
            end
            StReport: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // abort outranks out_ready; both end in IDLE but abort delivers nothing
                if (abort || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            det_q   <= DetD0;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
    assign det_z     = (det_q == DetD4);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: default 16-bit instance plus a 32-bit,
// 2-bit-counter instance for saturation. Inputs driven and outputs sampled on negedge.
module tb_seq_detect_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, abort, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, busy, det_z;
    logic [4:0]  match_cnt;

    logic        b_in_valid, b_abort, b_out_ready;
    logic [31:0] b_in_data;
    logic        b_in_ready, b_out_valid, b_busy, b_det_z;
    logic [1:0]  b_match_cnt;

    int compared   = 0;
    int mismatched = 0;

    seq_detect_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .abort    (abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .match_cnt(match_cnt),
        .busy     (busy),
        .det_z    (det_z)
    );

    seq_detect_ctrl #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .abort    (b_abort),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .match_cnt(b_match_cnt),
        .busy     (b_busy),
        .det_z    (b_det_z)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the edge entering REPORT.
    task automatic scan(input logic [15:0] data, input int exp_pre, input int exp_cnt,
                        input int exp_pulses, input string tag);
        int   pulses;
        logic prev;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        pulses = 0;
        prev   = det_z;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (det_z && !prev) pulses++;
            prev = det_z;
            if (i == 15) begin
                check({tag, "_cnt_pre"}, 64'(match_cnt), 64'(exp_pre));
                check({tag, "_ov_early"}, 64'(out_valid), 64'd0);
            end
        end
        check({tag, "_ov"}, 64'(out_valid), 64'd1);
        check({tag, "_cnt"}, 64'(match_cnt), 64'(exp_cnt));
        check({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
        check({tag, "_in_ready_rep"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        int cyc;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        abort       = 1'b0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_abort     = 1'b0;
        b_out_ready = 1'b0;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_det_z", 64'(det_z), 64'd0);
        check("rst_cnt", 64'(match_cnt), 64'd0);
        check("rst_b_cnt", 64'(b_match_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic scans with immediate acceptance
        out_ready = 1'b1;
        scan(16'hCCCC, 3, 4, 4, "cccc");
        @(negedge clk);
        check("cccc_done_ov", 64'(out_valid), 64'd0);
        check("cccc_done_busy", 64'(busy), 64'd0);
        scan(16'hFFFF, 0, 0, 0, "ffff");
        @(negedge clk);
        scan(16'h0000, 0, 0, 0, "zero");
        @(negedge clk);
        scan(16'h000C, 0, 1, 1, "000c");
        @(negedge clk);
        scan(16'hC000, 1, 1, 1, "c000");
        @(negedge clk);

        // Consumer stall in REPORT
        out_ready = 1'b0;
        scan(16'hCCCC, 3, 4, 4, "hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_ov", 64'(out_valid), 64'd1);
            check("hold_cnt", 64'(match_cnt), 64'd4);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_rel_ov", 64'(out_valid), 64'd0);
        check("hold_rel_in_ready", 64'(in_ready), 64'd1);

        // No back-to-back accept from REPORT
        scan(16'hC000, 1, 1, 1, "b2b_first");
        in_valid = 1'b1;
        in_data  = 16'hCCCC;
        @(negedge clk);
        check("b2b_not_taken", 64'(busy), 64'd0);
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_taken", 64'(busy), 64'd1);
        for (int i = 0; i < 16; i++) @(negedge clk);
        check("b2b_ov", 64'(out_valid), 64'd1);
        check("b2b_cnt", 64'(match_cnt), 64'd4);
        @(negedge clk);

        // Abort on the 3rd SHIFT cycle; detector left in D2 must not leak into the next word
        in_valid = 1'b1;
        in_data  = 16'hCCCC;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ov", 64'(out_valid), 64'd0);
        scan(16'h000C, 0, 1, 1, "after_abort");
        @(negedge clk);

        // Abort in REPORT wins over out_ready
        scan(16'hFFFF, 0, 0, 0, "rep_abort");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("rep_abort_ov", 64'(out_valid), 64'd0);
        check("rep_abort_in_ready", 64'(in_ready), 64'd1);

        // Abort in IDLE is ignored
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hC000;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 16; i++) @(negedge clk);
        check("idle_abort_ov", 64'(out_valid), 64'd1);
        check("idle_abort_cnt", 64'(match_cnt), 64'd1);
        @(negedge clk);

        // Asynchronous reset mid-SHIFT, right after the first detection
        in_valid = 1'b1;
        in_data  = 16'hCCCC;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("mid_det_z", 64'(det_z), 64'd1);
        check("mid_cnt", 64'(match_cnt), 64'd1);
        reset = 1'b1;
        #1;
        check("arst_cnt", 64'(match_cnt), 64'd0);
        check("arst_det_z", 64'(det_z), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_ov", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        scan(16'hCCCC, 3, 4, 4, "post_reset");
        @(negedge clk);

        // Saturation on the 32-bit / 2-bit instance
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 32'hCCCCCCCC;
        @(negedge clk);
        b_in_valid = 1'b0;
        cyc = 0;
        while (!b_out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("sat_latency", 64'(cyc), 64'd32);
        check("sat_cnt", 64'(b_match_cnt), 64'd3);
        @(negedge clk);
        check("sat_done_ov", 64'(b_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
